// File: rtl/prog_loader_uart.sv
// UART (8N1) program loader: receives an A5/LEN/DATA[/CHK] frame and writes it into the program BRAM.
// Optional trailing XOR checksum byte enabled by defining PLOADER_CHECKSUM_EN.
module prog_loader_uart #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);
  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_BITS, R_STOP} rx_state_t;
`ifdef PLOADER_CHECKSUM_EN
  typedef enum logic [1:0] {F_SYNC, F_LEN, F_DATA, F_CHK} fr_state_t;
  logic [7:0] acc_q, acc_d;
`else
  typedef enum logic [1:0] {F_SYNC, F_LEN, F_DATA} fr_state_t;
  logic       last_q, last_d;
`endif

  rx_state_t   rs_q, rs_d;
  fr_state_t   fs_q, fs_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        bv_q, bv_d, fe_q, fe_d;
  logic [8:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;

  // Receiver: counts from the synchronized falling edge and samples mid-bit.
  always_comb begin
    rs_d  = rs_q;
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    sh_d  = sh_q;
    bv_d  = 1'b0;
    fe_d  = 1'b0;
    case (rs_q)
      R_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rs_d = R_START;
        else                       rs_d = R_IDLE;
      end
      R_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d = '0;
          bit_d = 3'd0;
          if (!rx_s2_q) rs_d = R_BITS;
          else          rs_d = R_IDLE;
        end else begin
          rs_d = R_START;
        end
      end
      R_BITS: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d = '0;
          sh_d  = {rx_s2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) rs_d = R_STOP;
          else               rs_d = R_BITS;
        end else begin
          rs_d = R_BITS;
        end
      end
      R_STOP: begin
        if (cnt_q == CW'(DIV - 1)) begin
          bv_d = rx_s2_q;
          fe_d = !rx_s2_q;
          rs_d = R_IDLE;
        end else begin
          rs_d = R_STOP;
        end
      end
      default: rs_d = R_IDLE;
    endcase
  end

  // Frame parser: address advances the clk after each write strobe.
  always_comb begin
    fs_d   = fs_q;
    addr_d = we_q ? addr_q + ADDR_W'(1) : addr_q;
    data_d = data_q;
    we_d   = 1'b0;
    hold_d = hold_q;
    done_d = 1'b0;
    err_d  = err_q;
    rem_d  = rem_q;
`ifdef PLOADER_CHECKSUM_EN
    acc_d  = acc_q;
`else
    last_d = 1'b0;
    if (we_q && last_q) begin
      done_d = 1'b1;
      hold_d = 1'b0;
    end else begin
      done_d = 1'b0;
    end
`endif
    if (fe_q && fs_q != F_SYNC) begin
      err_d = 1'b1;
      fs_d  = F_SYNC;
    end else if (bv_q) begin
      case (fs_q)
        F_SYNC: begin
          if (sh_q == 8'hA5) begin
            addr_d = '0;
            err_d  = 1'b0;
            hold_d = 1'b1;
            fs_d   = F_LEN;
`ifdef PLOADER_CHECKSUM_EN
            acc_d  = 8'h00;
`endif
          end else begin
            fs_d = F_SYNC;
          end
        end
        F_LEN: begin
          rem_d = (sh_q == 8'h00) ? 9'd256 : {1'b0, sh_q};
          fs_d  = F_DATA;
        end
        F_DATA: begin
          we_d   = 1'b1;
          data_d = sh_q;
          rem_d  = rem_q - 9'd1;
`ifdef PLOADER_CHECKSUM_EN
          acc_d  = acc_q ^ sh_q;
          if (rem_q == 9'd1) fs_d = F_CHK;
          else               fs_d = F_DATA;
`else
          last_d = (rem_q == 9'd1);
          if (rem_q == 9'd1) fs_d = F_SYNC;
          else               fs_d = F_DATA;
`endif
        end
`ifdef PLOADER_CHECKSUM_EN
        F_CHK: begin
          if (sh_q == acc_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          fs_d = F_SYNC;
        end
`endif
        default: fs_d = F_SYNC;
      endcase
    end else begin
      fs_d = fs_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
      rs_q <= R_IDLE; cnt_q <= '0; bit_q <= 3'd0; sh_q <= 8'h00;
      bv_q <= 1'b0; fe_q <= 1'b0;
      fs_q <= F_SYNC; rem_q <= 9'd0; addr_q <= '0; data_q <= 8'h00;
      we_q <= 1'b0; hold_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
`ifdef PLOADER_CHECKSUM_EN
      acc_q <= 8'h00;
`else
      last_q <= 1'b0;
`endif
    end else begin
      rx_s1_q <= rxd; rx_s2_q <= rx_s1_q; rx_prev_q <= rx_s2_q;
      rs_q <= rs_d; cnt_q <= cnt_d; bit_q <= bit_d; sh_q <= sh_d;
      bv_q <= bv_d; fe_q <= fe_d;
      fs_q <= fs_d; rem_q <= rem_d; addr_q <= addr_d; data_q <= data_d;
      we_q <= we_d; hold_q <= hold_d; done_q <= done_d; err_q <= err_d;
`ifdef PLOADER_CHECKSUM_EN
      acc_q <= acc_d;
`else
      last_q <= last_d;
`endif
    end
  end

  assign ram_addr  = addr_q;
  assign ram_data  = data_q;
  assign ram_we    = we_q;
  assign cpu_hold  = hold_q;
  assign load_done = done_q;
  assign load_err  = err_q;
endmodule

// File: doc/prog_loader_uart.md
# prog_loader_uart

Serial program loader that sits directly upstream of the FCPU program memory. It receives a framed program image over a UART line (8N1) and writes it byte-by-byte into the write port of the CPU's 2048×8 program BRAM. It holds the CPU stalled while a load is in progress and reports completion or failure. After a successful load the CPU restarts from address 0 with the new image.

## Interface
Parameters:
- CLK_HZ, 50_000_000 — system clock frequency in Hz.
- BAUD, 115200 — serial bit rate; bit period DIV = CLK_HZ/BAUD clocks, integer-truncated (434 at defaults).
- ADDR_W, 11 — program RAM address width, matching the BRAM port.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rxd  in  1  asynchronous serial input, idle high.
- ram_addr  out  ADDR_W  BRAM write address.
- ram_data  out  8  BRAM write data.
- ram_we  out  1  BRAM write strobe, one clk wide per byte.
- cpu_hold  out  1  high while the CPU must stay stalled and reset.
- load_done  out  1  one-clk pulse on successful frame completion.
- load_err  out  1  level, high after a failed frame until the next sync byte.

## Operation
- rxd passes through a 2-flop synchronizer before any use.
- Receiver FSM states:
  - R_IDLE: waits for a falling edge on the synchronized input.
  - R_START: waits DIV/2 clocks, then samples. A low sample goes to R_BITS; a high sample is a glitch and returns to R_IDLE.
  - R_BITS: samples 8 data bits, LSB first, every DIV clocks.
  - R_STOP: samples the stop bit after DIV clocks. High gives byte_valid for 1 clk. Low gives frame_err for 1 clk. Either way the FSM returns to R_IDLE.
- Frame FSM states:
  - F_SYNC: ignores every byte except 0xA5. On 0xA5, clears ram_addr, the checksum accumulator and load_err, asserts cpu_hold, and goes to F_LEN.
  - F_LEN: the byte is N. N=0 means 256. Stores the remaining count and goes to F_DATA.
  - F_DATA: each byte drives ram_data and pulses ram_we. ram_addr increments after the write. The byte is XORed into the accumulator. After the Nth byte, goes to F_CHK.
  - F_CHK: the received byte is compared with the accumulator. On a match, pulses load_done, drops cpu_hold and goes to F_SYNC. On a mismatch, sets load_err, keeps cpu_hold high and goes to F_SYNC.
- A frame_err in any state other than F_SYNC aborts the frame: load_err=1, cpu_hold stays 1, return to F_SYNC.
- A frame_err in F_SYNC is ignored.
- cpu_hold remains high after an error until a later frame completes successfully. Running a partially overwritten image is forbidden.
- ram_addr wraps modulo 2^ADDR_W. With N≤256 and ADDR_W=11 a wrap cannot occur.
- A 0xA5 byte in F_LEN, F_DATA or F_CHK is treated as data, not as a resync.

## Timing
- Reset values: ram_addr=0, ram_data=0, ram_we=0, cpu_hold=0, load_done=0, load_err=0. Both FSMs return to their idle states.
- A reset mid-frame discards the partial frame. Bytes already written stay in RAM; cpu_hold drops to 0.
- Sample points: the start bit is sampled at DIV/2 clocks after the detected edge. Data bit k is sampled at DIV/2 + (k+1)·DIV. The stop bit is sampled at DIV/2 + 9·DIV.
- Sampling is referenced to the synchronized edge, which lags the pin by 2 clks.
- byte_valid is asserted the clk after the stop-bit sample.
- ram_we and ram_data are registered and asserted the clk after byte_valid.
- ram_addr holds the write address during ram_we and increments on the following clk.
- cpu_hold rises the clk after the 0xA5 byte_valid.
- load_done and the fall of cpu_hold occur on the same clk, one clk after the checksum byte_valid.
- Back-to-back bytes with no idle gap must be received: after the stop sample, the receiver is back in R_IDLE before the next start edge.

## Configuration
- PLOADER_CHECKSUM_EN:
  - Defined: the F_CHK state exists and the frame carries a trailing XOR checksum byte, as described above.
  - Undefined: F_CHK and the accumulator are removed. load_done pulses and cpu_hold drops one clk after the ram_we of the Nth data byte. load_err is caused by framing errors only.

## Test plan
- Frame A5 03 42 05 11 (checksum 0x42^0x05^0x11 = 0x56), then 56 at 115200 baud → three ram_we pulses writing addr 0/1/2 = 42/05/11. cpu_hold high from after A5 to the load_done pulse. load_err stays 0.
- Same frame with checksum 57 → all three bytes written, load_err=1, cpu_hold stays 1, no load_done. A following correct frame clears load_err and drops cpu_hold.
- Bytes 00 FF 3C before A5 01 7E 7E → only one write: addr0=7E. The leading bytes are ignored.
- A 0.25-bit low glitch on rxd while idle → no byte_valid, no state change.
- Stop bit forced low on the second data byte of a 3-byte frame → load_err=1 and the frame aborts. Exactly one ram_we has occurred.
- rst_n low for 1 clk after two of four data bytes → all outputs return to 0 the next clk. A subsequent full frame A5 01 AA AA loads addr0=AA normally.
